// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and sizes for the matrix-multiply datapath
package matmul_pkg;

    // Default sizes shared with the PE array and adder tree
    localparam int DEF_N_ROWS         = 64;
    localparam int DEF_N_COLS         = 64;
    localparam int DEF_ADDR_IN_WIDTH  = 6;
    localparam int DEF_ADDR_OUT_WIDTH = 12;
    localparam int DEF_MEM_LATENCY    = 1;
    localparam int DEF_TREE_LATENCY   = 7;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Cycles from a read issue until its adder-tree result is ready to write
    function automatic int pipe_lat(input int mem_latency, input int tree_latency);
        return mem_latency + tree_latency;
    endfunction

    localparam int PIPE_LAT = DEF_MEM_LATENCY + DEF_TREE_LATENCY;

endpackage

// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - sequencer control and memory-port bundle
interface matmul_sequencer_if #(
    parameter int ADDR_IN_WIDTH  = 6,
    parameter int ADDR_OUT_WIDTH = 12
);
    logic                      start;
    logic                      en_a;
    logic                      en_b;
    logic                      we_a;
    logic                      we_b;
    logic [ADDR_IN_WIDTH-1:0]  addr_a;
    logic [ADDR_IN_WIDTH-1:0]  addr_b;
    logic                      en_out;
    logic                      we_out;
    logic [ADDR_OUT_WIDTH-1:0] addr_out;
    logic                      busy;
    logic                      done;

    // Sequencer side: takes start, drives the memory ports and status
    modport master (
        input  start,
        output en_a, en_b, we_a, we_b, addr_a, addr_b,
        output en_out, we_out, addr_out, busy, done
    );

    // Controller / memory side
    modport slave (
        output start,
        input  en_a, en_b, we_a, we_b, addr_a, addr_b,
        input  en_out, we_out, addr_out, busy, done
    );
endinterface

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth shift register carrying a valid token
module valid_delay_line #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in,
    output logic out,
    output logic empty
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    generate
        if (DEPTH == 1) begin : g_single
            // Next stage contents: just the incoming token
            always_comb begin
                shift_d = clr ? 1'b0 : in;
            end
            // Nothing remains behind the output stage
            assign empty = 1'b1;
        end else begin : g_multi
            // Next stage contents: shift toward the output, new token at stage 0
            always_comb begin
                shift_d = clr ? '0 : {shift_q[DEPTH-2:0], in};
            end
            // Empty means no token is pending beyond the one leaving this cycle,
            // so the caller can finish in the same cycle as the final write
            assign empty = ~|shift_q[DEPTH-2:0];
        end
    endgenerate

    // Stage register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - read-issue and result-write sequencer for matrix multiply
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N_ROWS         = DEF_N_ROWS,
    parameter int N_COLS         = DEF_N_COLS,
    parameter int ADDR_IN_WIDTH  = DEF_ADDR_IN_WIDTH,
    parameter int ADDR_OUT_WIDTH = DEF_ADDR_OUT_WIDTH,
    parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
    parameter int TREE_LATENCY   = DEF_TREE_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    matmul_sequencer_if.master bus
);

    localparam int PIPE = pipe_lat(MEM_LATENCY, TREE_LATENCY);
    localparam logic [ADDR_IN_WIDTH-1:0] I_LAST = ADDR_IN_WIDTH'(N_ROWS - 1);
    localparam logic [ADDR_IN_WIDTH-1:0] J_LAST = ADDR_IN_WIDTH'(N_COLS - 1);

    seq_state_e                state_q, state_d;
    logic [ADDR_IN_WIDTH-1:0]  i_q, i_d;
    logic [ADDR_IN_WIDTH-1:0]  j_q, j_d;
    logic [ADDR_OUT_WIDTH-1:0] k_out_q, k_out_d;

    logic issue;
    logic dl_clr;
    logic dl_out;
    logic dl_empty;

    valid_delay_line #(
        .DEPTH (PIPE)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dl_clr),
        .in    (issue),
        .out   (dl_out),
        .empty (dl_empty)
    );

    // Next-state, loop counters and output counter
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_out_d = dl_out ? k_out_q + ADDR_OUT_WIDTH'(1) : k_out_q;
        issue   = 1'b0;
        dl_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                k_out_d = '0;
                dl_clr  = 1'b1;
                // i/j are zeroed at acceptance so addr_a/addr_b keep the
                // final address of the previous run while idle
                if (bus.start) begin
                    state_d = ST_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (j_q == J_LAST) begin
                    if (i_q == I_LAST) begin
                        // Last pair issued: hold i/j so the address outputs stay put
                        state_d = ST_DRAIN;
                    end else begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dl_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_out_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_out_q <= k_out_d;
        end
    end

    // Memory ports and status are decoded straight from registered state
    assign bus.en_a     = (state_q == ST_ISSUE);
    assign bus.en_b     = (state_q == ST_ISSUE);
    assign bus.we_a     = 1'b0;
    assign bus.we_b     = 1'b0;
    assign bus.addr_a   = i_q;
    assign bus.addr_b   = j_q;
    assign bus.en_out   = dl_out;
    assign bus.we_out   = dl_out;
    assign bus.addr_out = k_out_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);

endmodule
